// File: rtl/trade_history_buffer_pkg.sv
// Price constants shared by the matching engine, the trade history buffer and the display.
// Statistic init values are chosen so that the first capture after reset/clear sets both high and low.
package trade_history_buffer_pkg;

  localparam int              PRICE_W         = 8;
  localparam logic [PRICE_W-1:0] PRICE_LOW_INIT  = 8'hFF;
  localparam logic [PRICE_W-1:0] PRICE_HIGH_INIT = 8'h00;

endpackage

// File: rtl/trade_history_buffer_if.sv
// Trade input, control and chart read-port bundle between the engine/controller/renderer and the history buffer.
// master = the driving side (engine, controller, renderer), slave = the history buffer.
interface trade_history_buffer_if
  import trade_history_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PW    = PRICE_W
);
    localparam int AW = $clog2(DEPTH);

    logic          trade_valid;
    logic [PW-1:0] trade_price;
    logic          enable;
    logic          halt;
    logic          clear;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic [PW-1:0] last_price;
    logic [PW-1:0] high_price;
    logic [PW-1:0] low_price;
    logic          new_trade;

    modport master (
        output trade_valid, trade_price, enable, halt, clear, rd_addr,
        input  rd_data, rd_valid, count, last_price, high_price, low_price, new_trade
    );

    modport slave (
        input  trade_valid, trade_price, enable, halt, clear, rd_addr,
        output rd_data, rd_valid, count, last_price, high_price, low_price, new_trade
    );

endinterface

// File: rtl/trade_history_buffer_ram.sv
// Trade RAM: simple dual-port history store, one write port and one registered read port.
// Read returns pre-write contents on an address collision; the array is not reset so it maps to block RAM.
module trade_history_buffer_ram #(
    parameter int DEPTH = 64,
    parameter int PW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [PW-1:0] rd_q
);

    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

endmodule

// File: rtl/trade_history_buffer.sv
// Circular history of the last DEPTH trade prices with session last/high/low statistics.
// Chart reads are addressed by age (0 = newest) with one cycle of latency.
module trade_history_buffer
  import trade_history_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PW    = PRICE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    trade_history_buffer_if.slave  bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    function automatic logic [AW:0] count_sat(input logic [AW:0] c);
        return (c == DEPTH_CNT) ? c : c + 1'b1;
    endfunction

    logic          trade_valid_p1;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic [PW-1:0] last_q;
    logic [PW-1:0] high_q;
    logic [PW-1:0] low_q;
    logic          new_trade_q;
    logic          rd_valid_p1;
    logic [PW-1:0] ram_q_p1;

    logic          trade_evt;
    logic          capture;
    logic [AW-1:0] rd_phys;
    logic          rd_hit;

    // Request stage: edge detect, capture qualification and age-to-address translation
    assign trade_evt = bus.trade_valid & ~trade_valid_p1;
    assign capture   = trade_evt & bus.enable & ~bus.halt & ~bus.clear;
    assign rd_phys   = wr_ptr - AW'(1) - bus.rd_addr;
    assign rd_hit    = ({1'b0, bus.rd_addr} < count_q);

    trade_history_buffer_ram #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clk     (clk),
        .we      (capture),
        .wr_addr (wr_ptr),
        .wr_data (bus.trade_price),
        .rd_addr (rd_phys),
        .rd_q    (ram_q_p1)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trade_valid_p1 <= 1'b0;
            wr_ptr         <= '0;
            count_q        <= '0;
            last_q         <= '0;
            high_q         <= PW'(PRICE_HIGH_INIT);
            low_q          <= PW'(PRICE_LOW_INIT);
            new_trade_q    <= 1'b0;
            rd_valid_p1    <= 1'b0;
        end else begin
            // Edge register keeps tracking while halted so resume never fakes an event
            trade_valid_p1 <= bus.trade_valid;
            new_trade_q    <= capture;
            rd_valid_p1    <= rd_hit;
            if (bus.clear) begin
                wr_ptr  <= '0;
                count_q <= '0;
                last_q  <= '0;
                high_q  <= PW'(PRICE_HIGH_INIT);
                low_q   <= PW'(PRICE_LOW_INIT);
            end else if (capture) begin
                wr_ptr  <= wr_ptr + AW'(1);
                count_q <= count_sat(count_q);
                last_q  <= bus.trade_price;
                if (bus.trade_price > high_q) high_q <= bus.trade_price;
                if (bus.trade_price < low_q)  low_q  <= bus.trade_price;
            end
        end
    end

    // Output stage: read data forced to zero for ages beyond the stored count
    assign bus.rd_data    = rd_valid_p1 ? ram_q_p1 : '0;
    assign bus.rd_valid   = rd_valid_p1;
    assign bus.count      = count_q;
    assign bus.last_price = last_q;
    assign bus.high_price = high_q;
    assign bus.low_price  = low_q;
    assign bus.new_trade  = new_trade_q;

endmodule

// File: doc/trade_history_buffer.md
# trade_history_buffer

Downstream consumer of the matching engine's trade stream: records every executed trade price into a circular history of the last DEPTH trades and tracks session last/high/low prices. Sits between the matching engine / controller and the VGA analytics renderer, which reads history entries by age through a synchronous read port to draw the price chart. Writes are gated by the controller's count-enable and halt outputs, so the chart freezes exactly when trading halts.

## Interface
- DEPTH, 64, history entries; power of two, 4..256
- AW, log2(DEPTH), address width (derived, not overridden)
- PW, 8, price width; matches matching-engine trade_price
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-low reset
- trade_valid  in  1  match flag from the matching engine; level, may stay high multiple cycles
- trade_price  in  PW  trade price, valid whenever trade_valid=1
- enable  in  1  controller count-enable; writes only when 1
- halt  in  1  controller halt flag; writes blocked when 1
- clear  in  1  synchronous history clear, one-cycle pulse
- rd_addr  in  AW  age index: 0 = newest, count-1 = oldest
- rd_data  out  PW  entry at rd_addr, one cycle later
- rd_valid  out  1  rd_data holds a stored entry (rd_addr < count at request)
- count  out  AW+1  stored entries, saturates at DEPTH
- last_price  out  PW  most recent captured price
- high_price  out  PW  maximum captured since reset/clear
- low_price  out  PW  minimum captured since reset/clear
- new_trade  out  1  one-cycle pulse, cycle after each capture (renderer redraw)

## Operation
- Trade event = rising edge of trade_valid (trade_valid=1, registered previous value=0); a held flag is one event.
- Capture when event AND enable=1 AND halt=0: mem[wr_ptr] <= trade_price; wr_ptr <= wr_ptr+1 (wraps mod DEPTH); count <= min(count+1, DEPTH); last_price <= trade_price; high/low updated by comparison with incoming price (unsigned).
- Events while enable=0 or halt=1 are dropped, not queued; the edge detector still tracks trade_valid so no spurious event on resume.
- Full buffer: capture overwrites oldest entry; count stays DEPTH.
- clear: wr_ptr<=0, count<=0, last_price<=0, high<=0x00, low<=0xFF; RAM contents untouched. clear has priority over a same-cycle capture (capture discarded, no new_trade).
- Read: physical address = (wr_ptr - 1 - rd_addr) mod DEPTH using wr_ptr of the request cycle; rd_valid = (rd_addr < count) of request cycle; rd_data = 0 when not valid.
- Read/write collision: read returns pre-write contents (read-old-data), consistent with the pre-write wr_ptr snapshot.
- Reset values: wr_ptr 0, count 0, last_price 0, high_price 0x00, low_price 0xFF, new_trade 0, rd_data 0, rd_valid 0, edge register 0. RAM not reset.

## Timing
- Capture: trade_valid rises in cycle N -> memory, pointers, count, last/high/low updated at edge ending N; new_trade=1 during N+1.
- Read latency exactly 1 cycle; new rd_addr accepted every cycle.
- A read issued in cycle N+1 at rd_addr=0 returns the price captured in N.
- Reset asserted mid-operation: all registers return to reset values immediately (async); first capture after release lands in mem[0].
- Back-to-back events need trade_valid to drop for ≥1 cycle; max capture rate one per 2 cycles.

## Structure
- Shared package/header: PRICE_W=8, PRICE_LOW_INIT=0xFF, PRICE_HIGH_INIT=0x00, shared with matching engine and display.
- One sub-module: trade_ram, simple dual-port (1 write, 1 registered read), read-old-data, inferred as M10K; no reset on array.
- Top holds edge detector, pointer/count logic, statistics registers, read address arithmetic.

## Test plan
- Reset then trade_valid high 5 cycles with price 0x40, enable=1 -> one capture: count=1, last=high=low=0x40, single new_trade pulse; rd_addr=0 -> rd_data=0x40, rd_valid=1; rd_addr=1 -> rd_valid=0, rd_data=0.
- 70 events, prices 1..70, DEPTH=64 -> count=64, rd_addr=0 -> 70, rd_addr=63 -> 7, high=70, low=1, wr_ptr wrapped to 6.
- Event with halt=1 (price 0x99) then halt=0, trade_valid still high -> no capture, no new_trade, count unchanged; next genuine edge captured.
- clear coincident with event (price 0x55) -> count=0, last=0, high=0x00, low=0xFF, no new_trade; next event price 0x20 lands at rd_addr=0.
- Read rd_addr=0 in same cycle as capture of 0x30 after previous newest 0x10 -> rd_data=0x10; next cycle rd_addr=0 -> 0x30.
- Assert reset (low) mid-stream after 10 captures -> all outputs to reset values asynchronously; after release, first capture 0x77 read back at rd_addr=0, count=1.
